// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a start/busy/done handshake and a register-file write port.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIVU/REMU write back 0 immediately.
module muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic             reg_we,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] wd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic [4:0]         rd_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic               fast;
    logic [WIDTH-1:0]   fast_res, calc_res;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH:0]   rem_sh, rem_diff;

    // Partial remainder gets the next dividend bit; a borrow in rem_diff means restore.
    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvs};
    assign fast     = op[1] && (rs2_val == '0);
    assign fast_res = op[0] ? rs1_val : '1;
`else
    assign fast     = op[1];
    assign fast_res = '0;
`endif

    always_comb begin
        calc_res = '0;
        case (op_q)
            2'b00:   calc_res = acc[WIDTH-1:0];
            2'b01:   calc_res = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            2'b10:   calc_res = quo;
            2'b11:   calc_res = rem;
`endif
            default: calc_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast ? WB : CALC;
            CALC:    if (cnt == LAST) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= '0;
            rd_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rd     <= '0;
            wd     <= '0;
`ifdef MULDIV_DIV_EN
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    rd_q   <= rd_in;
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, rs1_val};
                    mplier <= rs2_val;
`ifdef MULDIV_DIV_EN
                    rem    <= '0;
                    quo    <= rs1_val;
                    dvs    <= rs2_val;
`endif
                    if (fast) begin
                        rd <= rd_in;
                        wd <= fast_res;
                    end
                end
                CALC: if (cnt == LAST) begin
                    rd <= rd_q;
                    wd <= calc_res;
                end else begin
                    // Both datapaths step together; op_q picks which one is written back.
                    cnt    <= cnt + 1'b1;
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`ifdef MULDIV_DIV_EN
                    quo    <= {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
                    rem    <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == WB);
    assign reg_we = done && (rd != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] rs1_val = '0, rs2_val = '0;
    logic [4:0] rd_in = '0;
    logic       busy, done, reg_we;
    logic [4:0] rd;
    logic [7:0] wd;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .busy(busy), .done(done), .reg_we(reg_we), .rd(rd), .wd(wd)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands.
    function automatic logic [7:0] model_wd(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (o)
            2'd0: return p[7:0];
            2'd1: return p[15:8];
`ifdef MULDIV_DIV_EN
            2'd2: return (b == 0) ? 8'hFF : a / b;
            default: return (b == 0) ? a : a % b;
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    // Edges after the accept edge until done is first seen high.
    function automatic int model_lat(input logic [1:0] o, input logic [7:0] b);
`ifdef MULDIV_DIV_EN
        return (o[1] && b == 0) ? 0 : 9;
`else
        return o[1] ? 0 : 9;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0;
        rs1_val = 8'($urandom); rs2_val = 8'($urandom); rd_in = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] r);
        int lat;
        logic [7:0] ew;
        ew = model_wd(o, a, b);
        accept(o, a, b, r);
        chk({tag, " busy"}, busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, model_lat(o, b));
        chk({tag, " wd"}, wd, ew);
        chk({tag, " rd"}, rd, r);
        chk({tag, " reg_we"}, reg_we, (r != 0));
        @(posedge clk); #1;
        chk({tag, " done_clr"}, {busy, done, reg_we}, 3'b000);
        chk({tag, " wd_hold"}, {rd, wd}, {r, ew});
    endtask

    initial begin
        int n;
        logic [7:0] cw;
        logic [4:0] cr;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, reg_we, rd, wd}, '0);
        @(negedge clk); reset = 1'b1;

        run_op("mul_13x11", 2'd0, 8'd13, 8'd11, 5'd5);
        chk("mul_13x11 const", wd, 8'h8F);
        run_op("mulhu_ff", 2'd1, 8'hFF, 8'hFF, 5'd9);
        chk("mulhu_ff const", wd, 8'hFE);
        run_op("divu_200_7", 2'd2, 8'd200, 8'd7, 5'd3);
        run_op("remu_200_7", 2'd3, 8'd200, 8'd7, 5'd4);
        run_op("divu_by0", 2'd2, 8'h55, 8'h00, 5'd6);
        run_op("remu_by0", 2'd3, 8'h55, 8'h00, 5'd7);
        run_op("divu_9_3", 2'd2, 8'd9, 8'd3, 5'd8);
        run_op("mul_rd0", 2'd0, 8'd3, 8'd4, 5'd0);
        chk("mul_rd0 const", wd, 8'h0C);

        // A second start while busy must be dropped entirely.
        accept(2'd0, 8'd13, 8'd11, 5'd7);
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 2'd1; rs1_val = 8'd99; rs2_val = 8'd200; rd_in = 5'd3;
        @(posedge clk); #1; start = 1'b0;
        n = 0; cw = '0; cr = '0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) begin n++; cw = wd; cr = rd; end
        end
        chk("ignored_start ndone", n, 1);
        chk("ignored_start wd", cw, model_wd(2'd0, 8'd13, 8'd11));
        chk("ignored_start rd", cr, 5'd7);

        // Reset in the middle of CALC aborts with no write.
        accept(2'd1, 8'hF0, 8'h0F, 5'd12);
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset outs", {busy, done, reg_we, rd, wd}, '0);
        @(negedge clk); reset = 1'b1;
        n = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("midreset no_done", n, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            ro = 2'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_op("rand", ro, ra, rb, 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
